// File: rtl/mdu_defs.sv
// mdu_defs: shared definitions for the multiply/divide unit controller.
//   - MDUOp encodings as driven by the E-stage decode
//   - default busy latencies for multiply and divide
//   - controller state encoding and the iteration counter width
package mdu_defs;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'b000,
      MDU_MULT  = 3'b001,
      MDU_MULTU = 3'b010,
      MDU_DIV   = 3'b011,
      MDU_DIVU  = 3'b100,
      MDU_MTHI  = 3'b101,
      MDU_MTLO  = 3'b110,
      MDU_RSVD  = 3'b111
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int MULT_CYCLES_DEFAULT = 5;
   localparam int DIV_CYCLES_DEFAULT  = 10;
   localparam int CNT_W               = 8;

   // True for the four operations that occupy the unit for several cycles.
   function automatic logic is_arith_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   // True for the two divide operations.
   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational arithmetic core of the MDU.
// Ports:
//   a, b         in   32  rs / rt operands
//   op           in   3   MDUOp encoding (only mult/multu/div/divu matter)
//   result       out  64  {hi, lo} for the selected operation, 0 otherwise
//   div_by_zero  out  1   high for div/divu with b == 0
module mdu_arith
   import mdu_defs::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic        signed_div;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] quo_mag;
   logic [31:0] rem_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   // Signed divide is done on magnitudes and the signs re-applied afterwards.
   // This keeps the most-negative / -1 case well defined (it wraps to
   // 0x80000000) and gives truncation toward zero with the remainder taking
   // the sign of the dividend.
   always_comb begin
      signed_div = (op == MDU_DIV);
      mag_a      = (signed_div && a[31]) ? (~a + 32'd1) : a;
      mag_b      = (signed_div && b[31]) ? (~b + 32'd1) : b;
      quo_mag    = '0;
      rem_mag    = '0;
      if (b != 32'd0) begin
         quo_mag = mag_a / mag_b;
         rem_mag = mag_a % mag_b;
      end
      quo = (signed_div && (a[31] ^ b[31])) ? (~quo_mag + 32'd1) : quo_mag;
      rem = (signed_div && a[31]) ? (~rem_mag + 32'd1) : rem_mag;
   end

   // Select the 64-bit {hi, lo} pair; multiplies use sign- or zero-extended
   // operands so the low 64 bits of the product are exact.
   always_comb begin
      result = '0;
      case (op)
         MDU_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         MDU_MULTU: result = {32'd0, a} * {32'd0, b};
         MDU_DIV,
         MDU_DIVU:  result = {rem, quo};
         default:   result = '0;
      endcase
      div_by_zero = is_div_op(op) && (b == 32'd0);
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the E stage.
// Launches mult/multu/div/divu for a fixed number of busy cycles, then commits
// the result into HI/LO; mthi/mtlo write HI/LO immediately when idle.
// Ports:
//   clk             in   1   clock
//   reset           in   1   asynchronous active-high reset
//   E_MDU_A         in   32  rs operand
//   E_MDU_B         in   32  rt operand
//   E_MDU_MDUOp     in   3   operation code (see mdu_defs::mdu_op_e)
//   E_MDU_Start     out  1   an arithmetic op is being accepted this cycle
//   E_MDU_Busy      out  1   an operation is in flight (registered)
//   E_MDU_StallReq  out  1   Start | Busy, for the hazard unit
//   E_MDU_HI        out  32  architectural HI
//   E_MDU_LO        out  32  architectural LO
module mdu_ctrl
   import mdu_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_MDU_A,
   input  logic [31:0] E_MDU_B,
   input  logic [2:0]  E_MDU_MDUOp,
   output logic        E_MDU_Start,
   output logic        E_MDU_Busy,
   output logic        E_MDU_StallReq,
   output logic [31:0] E_MDU_HI,
   output logic [31:0] E_MDU_LO
);

   mdu_state_e       state_q;
   mdu_state_e       state_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [63:0]      pending_q;
   logic             pending_dz_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;

   logic [63:0]      arith_result;
   logic             arith_dz;
   logic             load_pending;
   logic             commit;
   logic             write_hi;
   logic             write_lo;

   mdu_arith u_arith (
      .a           (E_MDU_A),
      .b           (E_MDU_B),
      .op          (E_MDU_MDUOp),
      .result      (arith_result),
      .div_by_zero (arith_dz)
   );

   assign E_MDU_Start    = (state_q == ST_IDLE) && is_arith_op(E_MDU_MDUOp);
   assign E_MDU_Busy     = (state_q == ST_RUN);
   assign E_MDU_StallReq = E_MDU_Start | E_MDU_Busy;
   assign E_MDU_HI       = hi_q;
   assign E_MDU_LO       = lo_q;

   // Next-state logic. Ops arriving while RUN are deliberately ignored; the
   // counter holds the number of busy cycles left including the current one,
   // so the commit happens on the edge that ends the cycle where it reads 1.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      load_pending = 1'b0;
      commit       = 1'b0;
      write_hi     = 1'b0;
      write_lo     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (E_MDU_Start) begin
               load_pending = 1'b1;
               count_d      = is_div_op(E_MDU_MDUOp) ? CNT_W'(DIV_CYCLES)
                                                     : CNT_W'(MULT_CYCLES);
               state_d      = ST_RUN;
            end else if (E_MDU_MDUOp == MDU_MTHI) begin
               write_hi = 1'b1;
            end else if (E_MDU_MDUOp == MDU_MTLO) begin
               write_lo = 1'b1;
            end
         end
         ST_RUN: begin
            if (count_q <= CNT_W'(1)) begin
               commit  = 1'b1;
               count_d = '0;
               state_d = ST_IDLE;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   // State and counter registers; reset cancels any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Pending result captured at issue, plus whether it came from a divide by
   // zero, in which case the commit leaves HI/LO untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q    <= '0;
         pending_dz_q <= 1'b0;
      end else if (load_pending) begin
         pending_q    <= arith_result;
         pending_dz_q <= arith_dz;
      end
   end

   // Architectural HI/LO: written only by a commit or by mthi/mtlo.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         if (!pending_dz_q) begin
            hi_q <= pending_q[63:32];
            lo_q <= pending_q[31:0];
         end
      end else begin
         if (write_hi) hi_q <= E_MDU_A;
         if (write_lo) lo_q <= E_MDU_A;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl. Directed scenarios from the
// test plan followed by randomized operations checked against an arithmetic
// reference model of HI/LO.
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] E_MDU_A;
   logic [31:0] E_MDU_B;
   logic [2:0]  E_MDU_MDUOp;
   logic        E_MDU_Start;
   logic        E_MDU_Busy;
   logic        E_MDU_StallReq;
   logic [31:0] E_MDU_HI;
   logic [31:0] E_MDU_LO;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] hi_m     = '0;
   logic [31:0] lo_m     = '0;

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk            (clk),
      .reset          (reset),
      .E_MDU_A        (E_MDU_A),
      .E_MDU_B        (E_MDU_B),
      .E_MDU_MDUOp    (E_MDU_MDUOp),
      .E_MDU_Start    (E_MDU_Start),
      .E_MDU_Busy     (E_MDU_Busy),
      .E_MDU_StallReq (E_MDU_StallReq),
      .E_MDU_HI       (E_MDU_HI),
      .E_MDU_LO       (E_MDU_LO)
   );

   // Free-running clock, posedges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what {HI,LO} an arithmetic op produces, from plain
   // 64-bit integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint          q;
      longint          r;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned p;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: begin
            q = sa * sb;
            return q;
         end
         3'd2: begin
            p = ua * ub;
            return p;
         end
         3'd3: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            p = ua / ub;
            ua = ua % ub;
            return {ua[31:0], p[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Apply the model's commit rules for an accepted arithmetic op.
   task automatic model_commit(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
      logic [63:0] r;
      if ((op == 3'd3 || op == 3'd4) && b == 32'd0) return;
      r    = ref_result(op, a, b);
      hi_m = r[63:32];
      lo_m = r[31:0];
   endtask

   // Drives one op from an idle cycle (entered 3 time units after a posedge)
   // and waits, bounded, for Busy to fall. Returns what was observed; the
   // caller does the checking. Exits 3 units after the first idle posedge.
   task automatic issue_wait(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, output logic start_seen,
                             output int busy_n, output int stall_n,
                             output logic hold_ok);
      logic [31:0] hi0;
      logic [31:0] lo0;
      E_MDU_MDUOp = op;
      E_MDU_A     = a;
      E_MDU_B     = b;
      #1;
      start_seen = E_MDU_Start;
      stall_n    = E_MDU_StallReq ? 1 : 0;
      hi0        = E_MDU_HI;
      lo0        = E_MDU_LO;
      @(posedge clk);
      #3;
      E_MDU_MDUOp = 3'd0;
      E_MDU_A     = $urandom;
      E_MDU_B     = $urandom;
      busy_n      = 0;
      hold_ok     = 1'b1;
      while (E_MDU_Busy === 1'b1 && busy_n < 40) begin
         busy_n++;
         if (E_MDU_StallReq === 1'b1) stall_n++;
         if (E_MDU_HI !== hi0 || E_MDU_LO !== lo0) hold_ok = 1'b0;
         @(posedge clk);
         #3;
      end
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      E_MDU_MDUOp = 3'd0;
      E_MDU_A     = '0;
      E_MDU_B     = '0;
      #2;
      n_checks++;
      if (E_MDU_Busy !== 1'b0 || E_MDU_HI !== 32'd0 || E_MDU_LO !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_state busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
                  E_MDU_Busy, E_MDU_HI, E_MDU_LO);
      end
      E_MDU_MDUOp = 3'd1;
      #1;
      n_checks++;
      if (E_MDU_Start !== 1'b1 || E_MDU_StallReq !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_start_follows start=%b stall=%b expected 1 1",
                  E_MDU_Start, E_MDU_StallReq);
      end
      E_MDU_MDUOp = 3'd7;
      #1;
      n_checks++;
      if (E_MDU_Start !== 1'b0 || E_MDU_StallReq !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reserved_op_idle start=%b stall=%b expected 0 0",
                  E_MDU_Start, E_MDU_StallReq);
      end
      E_MDU_MDUOp = 3'd0;
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #3;
   endtask

   // Shared by the directed arithmetic scenarios: issue, then check start,
   // busy length, hold-before-commit and the committed HI/LO.
   task automatic test_arith(input string name, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input int exp_busy, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
      logic s;
      logic hold;
      int   busy_n;
      int   stall_n;
      issue_wait(op, a, b, s, busy_n, stall_n, hold);
      model_commit(op, a, b);
      n_checks++;
      if (s !== 1'b1 || busy_n != exp_busy || hold !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s_timing start=%b busy=%0d hold=%b expected 1 %0d 1",
                  name, s, busy_n, hold, exp_busy);
      end
      n_checks++;
      if (E_MDU_HI !== exp_hi || E_MDU_LO !== exp_lo || E_MDU_HI !== hi_m ||
          E_MDU_LO !== lo_m) begin
         n_fail++;
         $display("[TB] FAIL %s_result hi=%h lo=%h expected hi=%h lo=%h",
                  name, E_MDU_HI, E_MDU_LO, exp_hi, exp_lo);
      end
   endtask

   task automatic test_mthi_divu0();
      E_MDU_MDUOp = 3'd5;
      E_MDU_A     = 32'h1234;
      #1;
      n_checks++;
      if (E_MDU_Start !== 1'b0 || E_MDU_StallReq !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mthi_nostall start=%b stall=%b expected 0 0",
                  E_MDU_Start, E_MDU_StallReq);
      end
      @(posedge clk);
      #3;
      E_MDU_MDUOp = 3'd0;
      hi_m        = 32'h1234;
      n_checks++;
      if (E_MDU_HI !== 32'h1234 || E_MDU_Busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mthi_write hi=%h busy=%b expected 00001234 0",
                  E_MDU_HI, E_MDU_Busy);
      end
      test_arith("divu_zero", 3'd4, 32'd7, 32'd0, DIV_N, 32'h1234, lo_m);
   endtask

   task automatic test_ignore_and_reset();
      E_MDU_MDUOp = 3'd1;
      E_MDU_A     = 32'd5;
      E_MDU_B     = 32'd6;
      @(posedge clk);
      #3;
      E_MDU_MDUOp = 3'd0;
      repeat (2) begin
         @(posedge clk);
         #3;
      end
      E_MDU_MDUOp = 3'd6;
      E_MDU_A     = 32'hAAAA;
      #1;
      n_checks++;
      if (E_MDU_Start !== 1'b0 || E_MDU_Busy !== 1'b1 || E_MDU_StallReq !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL busy_ignores_op start=%b busy=%b stall=%b expected 0 1 1",
                  E_MDU_Start, E_MDU_Busy, E_MDU_StallReq);
      end
      @(posedge clk);
      #3;
      E_MDU_MDUOp = 3'd0;
      n_checks++;
      if (E_MDU_LO !== lo_m || E_MDU_HI !== hi_m || E_MDU_Busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mtlo_ignored hi=%h lo=%h busy=%b expected %h %h 1",
                  E_MDU_HI, E_MDU_LO, E_MDU_Busy, hi_m, lo_m);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (E_MDU_Busy !== 1'b0 || E_MDU_HI !== 32'd0 || E_MDU_LO !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset busy=%b hi=%h lo=%h expected 0 0 0",
                  E_MDU_Busy, E_MDU_HI, E_MDU_LO);
      end
      hi_m = '0;
      lo_m = '0;
      @(posedge clk);
      #3;
      reset = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #3;
      end
      n_checks++;
      if (E_MDU_Busy !== 1'b0 || E_MDU_HI !== 32'd0 || E_MDU_LO !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL no_commit_after_reset busy=%b hi=%h lo=%h expected 0 0 0",
                  E_MDU_Busy, E_MDU_HI, E_MDU_LO);
      end
   endtask

   task automatic test_back_to_back();
      logic s;
      logic hold;
      int   busy_n;
      int   stall_n;
      issue_wait(3'd1, 32'd7, 32'hFFFFFFF7, s, busy_n, stall_n, hold);
      model_commit(3'd1, 32'd7, 32'hFFFFFFF7);
      n_checks++;
      if (stall_n != MULT_N + 1 || busy_n != MULT_N) begin
         n_fail++;
         $display("[TB] FAIL stall_count stall=%0d busy=%0d expected %0d %0d",
                  stall_n, busy_n, MULT_N + 1, MULT_N);
      end
      n_checks++;
      if (E_MDU_HI !== hi_m || E_MDU_LO !== lo_m) begin
         n_fail++;
         $display("[TB] FAIL b2b_mult_result hi=%h lo=%h expected %h %h",
                  E_MDU_HI, E_MDU_LO, hi_m, lo_m);
      end
      issue_wait(3'd4, 32'd100, 32'd7, s, busy_n, stall_n, hold);
      model_commit(3'd4, 32'd100, 32'd7);
      n_checks++;
      if (s !== 1'b1 || busy_n != DIV_N || E_MDU_HI !== hi_m || E_MDU_LO !== lo_m) begin
         n_fail++;
         $display("[TB] FAIL b2b_divu start=%b busy=%0d hi=%h lo=%h expected 1 %0d %h %h",
                  s, busy_n, E_MDU_HI, E_MDU_LO, DIV_N, hi_m, lo_m);
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        hold;
      int          busy_n;
      int          stall_n;
      int          exp_busy;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'd0;
         if ($urandom_range(0, 5) == 0) a = 32'h80000000;
         if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
         if (op >= 3'd1 && op <= 3'd4) begin
            exp_busy = (op >= 3'd3) ? DIV_N : MULT_N;
            issue_wait(op, a, b, s, busy_n, stall_n, hold);
            model_commit(op, a, b);
            n_checks++;
            if (s !== 1'b1 || busy_n != exp_busy || hold !== 1'b1 ||
                E_MDU_HI !== hi_m || E_MDU_LO !== lo_m) begin
               n_fail++;
               $display("[TB] FAIL rand_arith op=%0d a=%h b=%h start=%b busy=%0d hold=%b hi=%h lo=%h expected busy=%0d hi=%h lo=%h",
                        op, a, b, s, busy_n, hold, E_MDU_HI, E_MDU_LO,
                        exp_busy, hi_m, lo_m);
            end
         end else begin
            E_MDU_MDUOp = op;
            E_MDU_A     = a;
            E_MDU_B     = b;
            #1;
            s = E_MDU_StallReq;
            @(posedge clk);
            #3;
            E_MDU_MDUOp = 3'd0;
            if (op == 3'd5) hi_m = a;
            if (op == 3'd6) lo_m = a;
            n_checks++;
            if (s !== 1'b0 || E_MDU_Busy !== 1'b0 || E_MDU_HI !== hi_m ||
                E_MDU_LO !== lo_m) begin
               n_fail++;
               $display("[TB] FAIL rand_simple op=%0d stall=%b busy=%b hi=%h lo=%h expected 0 0 %h %h",
                        op, s, E_MDU_Busy, E_MDU_HI, E_MDU_LO, hi_m, lo_m);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith("multu", 3'd2, 32'hFFFFFFFF, 32'h2, MULT_N,
                 32'h00000001, 32'hFFFFFFFE);
      test_arith("mult", 3'd1, 32'hFFFFFFFD, 32'h4, MULT_N,
                 32'hFFFFFFFF, 32'hFFFFFFF4);
      test_arith("div", 3'd3, 32'hFFFFFFF9, 32'h2, DIV_N,
                 32'hFFFFFFFF, 32'hFFFFFFFD);
      test_mthi_divu0();
      test_ignore_and_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the E stage of the pipelined MIPS core. Accepts mult/multu/div/divu/mthi/mtlo from the E-stage decode, runs each multiply or divide for a fixed number of cycles, and then commits the result to the architectural HI/LO registers. It drives a busy/stall request so the hazard unit can hold later MDU instructions in D. mfhi/mflo read HI/LO directly from the outputs.

## Interface
Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu.
- DIV_CYCLES, 10, number of busy cycles for div/divu.

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- E_MDU_A  in  32  rs operand.
- E_MDU_B  in  32  rt operand.
- E_MDU_MDUOp  in  3  operation code:
  - 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- E_MDU_Start  out  1  combinational; high when MDUOp is 001–100 and the unit is idle.
- E_MDU_Busy  out  1  registered; high while an operation is in flight.
- E_MDU_StallReq  out  1  combinational; equals E_MDU_Start | E_MDU_Busy.
- E_MDU_HI  out  32  architectural HI register.
- E_MDU_LO  out  32  architectural LO register.

## Operation
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter active.
- Reset, asynchronous: state=IDLE, counter=0, HI=0, LO=0, latched result=0.
  - Outputs after reset: Busy=0. Start and StallReq follow MDUOp.
- IDLE with op 001–100:
  - At the clock edge, compute the 64-bit result from A/B and latch it into a pending register.
  - Load the counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - HI/LO are not yet changed.
- IDLE with op 101 or 110: write A into HI or LO at the edge. Busy stays 0 and there is no latency.
- RUN:
  - Decrement the counter each edge.
  - On the edge where counter==1: write the pending result into HI/LO and go to IDLE.
- Result formats:
  - mult: {HI,LO} = signed(A) * signed(B), 64-bit.
  - multu: {HI,LO} = unsigned A * B.
  - div: LO = signed quotient (truncated toward zero), HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B==0): the full DIV_CYCLES busy period is still spent, and HI/LO are left unchanged at commit.
- Any MDUOp seen while in RUN is ignored: no restart, no mthi/mtlo write. The hazard unit guarantees this does not happen. Verification checks that the unit ignores it.
- Reserved op 111 behaves as none.

## Timing
- Start accepted at edge t0:
  - Busy=1 for cycles t0+1 through t0+N, where N is MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible and Busy=0 from cycle t0+N+1.
- StallReq is high in the issue cycle (through Start) and in all N busy cycles.
  - So an mfhi directly behind a mult stalls N+1 cycles in total and reads the committed value.
- Back-to-back operations: a new Start is accepted in cycle t0+N+1. There is no dead cycle.
- mthi/mtlo: HI/LO update at the same edge and are readable by the next E-stage instruction.
- Reset asserted mid-RUN:
  - The operation is cancelled immediately (asynchronous).
  - HI=LO=0 and Busy=0, with no partial commit.
- HI/LO change only at a commit edge or an mthi/mtlo edge.

## Structure
- Shared package/header (mdu_defs):
  - MDUOp encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - Default latency constants.
  - The state encoding (IDLE/RUN).
- One sub-module, mdu_arith:
  - Combinational unit that produces the 64-bit {hi,lo} from A, B and op.
  - Also produces a div_by_zero flag.
- The top level holds the FSM, the counter, the pending-result register and the HI/LO registers.

## Test plan
- Reset, then multu A=0xFFFFFFFF, B=0x2:
  - Busy high exactly 5 cycles.
  - At cycle 6, HI=0x00000001, LO=0xFFFFFFFE.
- mult A=0xFFFFFFFD (−3), B=0x4:
  - After 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF4.
  - Before commit, HI/LO still hold their old values.
- div A=0xFFFFFFF9 (−7), B=0x2:
  - Busy exactly 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x1234 then divu A=7, B=0:
  - HI=0x1234 the next cycle.
  - Divide is busy 10 cycles; HI=0x1234 and LO are unchanged afterwards.
- mult issued, then at busy cycle 3 apply MDUOp=mtlo with A=0xAAAA:
  - The mtlo is ignored.
  - Then assert reset at busy cycle 4: Busy drops immediately, HI=LO=0, and no commit occurs.
- StallReq check: mult issue cycle plus 5 busy cycles gives 6 high cycles; a divu issued in cycle t0+6 is accepted immediately.
